aes128_iter_ctrl: RTL and testbench



---
 rtl/aes128_iter_ctrl_if.sv | 42 ++++
 rtl/aes128_iter_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_aes128_iter_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_iter_ctrl_if.sv
// Handshake bundle for aes128_iter_ctrl: plaintext/key input stream, ciphertext output stream, status.
// blk_cnt exists only when AES128_ITER_BLKCNT_EN is defined.
interface aes128_iter_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

`ifdef AES128_ITER_BLKCNT_EN
    logic [CNT_W-1:0] blk_cnt;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy, blk_cnt
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy, blk_cnt
    );
`else
    // CNT_W only sizes blk_cnt; keep it referenced so both builds elaborate alike.
    if (CNT_W == 0) begin : g_cnt_w_unused
    end

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif
endinterface

// File: rtl/aes128_iter_ctrl.sv
// aes128_iter_ctrl: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional completed-block counter enabled by defining AES128_ITER_BLKCNT_EN.
module aes128_iter_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    aes128_iter_ctrl_if.slave io_aes
);
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NBYTES   = 16;
    localparam logic [3:0]  LAST_RND = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Byte 0 of the block sits at the highest packed index.
    typedef logic [NBYTES-1:0][BYTE_W-1:0] blk_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gmul(a, a);
        inv = sq;
        for (int i = 2; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic blk_t sub_shift(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(15 - (4 * c + r))] = sbox(s[4'(15 - (4 * ((c + r) % 4) + r))]);
            end
        end
        return o;
    endfunction

    function automatic blk_t mix_cols(input blk_t s);
        blk_t       o;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4'(15 - 4 * c)];
            a1 = s[4'(14 - 4 * c)];
            a2 = s[4'(13 - 4 * c)];
            a3 = s[4'(12 - 4 * c)];
            o[4'(15 - 4 * c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[4'(14 - 4 * c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[4'(13 - 4 * c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[4'(12 - 4 * c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One AES-128 key-schedule step: four new words from the previous round key.
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    blk_t           r_st;
    logic [127:0]   r_key;
    logic [3:0]     r_rnd;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;
    logic           w_in_ready_nxt;
    logic           w_out_valid_nxt;
    logic           w_busy_nxt;
    logic           w_accept;
    logic [127:0]   w_key_nxt;
    blk_t           w_sub_shift;
    blk_t           w_mix;
    blk_t           w_round;

    assign w_accept    = (r_state == S_IDLE) & io_aes.in_valid;
    assign w_key_nxt   = key_step(r_key, rcon(r_rnd));
    assign w_sub_shift = sub_shift(r_st);
    assign w_mix       = mix_cols(w_sub_shift);
    assign w_round     = ((r_rnd == LAST_RND) ? w_sub_shift : w_mix) ^ blk_t'(w_key_nxt);

    // State register plus the status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (io_aes.in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (r_rnd == LAST_RND) w_state_nxt = S_DONE;
            S_DONE:  if (io_aes.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b1;
        case (w_state_nxt)
            S_IDLE: begin
                w_in_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
            end
            S_DONE:  w_out_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    // Round datapath: pre-whitening on accept, then one round per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st  <= '0;
            r_key <= '0;
            r_rnd <= 4'd0;
        end else if (w_accept) begin
            r_st  <= blk_t'(io_aes.in_data ^ io_aes.in_key);
            r_key <= io_aes.in_key;
            r_rnd <= 4'd1;
        end else if (r_state == S_RUN) begin
            r_st  <= w_round;
            r_key <= w_key_nxt;
            if (r_rnd != LAST_RND) r_rnd <= r_rnd + 4'd1;
        end
    end

    assign io_aes.in_ready  = r_in_ready;
    assign io_aes.out_valid = r_out_valid;
    assign io_aes.out_data  = 128'(r_st);
    assign io_aes.busy      = r_busy;

`ifdef AES128_ITER_BLKCNT_EN
    logic [CNT_W-1:0] r_blk_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_cnt <= '0;
        end else if (r_out_valid & io_aes.out_ready) begin
            r_blk_cnt <= r_blk_cnt + CNT_W'(1);
        end
    end

    assign io_aes.blk_cnt = r_blk_cnt;
`else
    // CNT_W only sizes blk_cnt; keep it referenced so both builds elaborate alike.
    if (CNT_W == 0) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Self-checking bench for aes128_iter_ctrl: FIPS-197 vectors, handshake timing, reset and random blocks.
// blk_cnt checks are compiled in only when AES128_ITER_BLKCNT_EN is defined.
module tb_aes128_iter_ctrl;
    localparam int unsigned TB_CNT_W = 2;
    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [7:0] sb [256];

    aes128_iter_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    aes128_iter_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_aes (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: polynomial multiply then reduce modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a [4];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[7'(127 - 32 * i) -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                rc  = gf_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[7'(127 - 8 * k) -: 8] ^ w[k / 4][5'(31 - 8 * (k % 4)) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sb[s[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4 * c + row] = s[4 * ((c + row) % 4) + row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++) a[row] = t[4 * c + row];
                    t[4 * c + 0] = gf_mul(a[0], 8'h02) ^ gf_mul(a[1], 8'h03) ^ a[2] ^ a[3];
                    t[4 * c + 1] = a[0] ^ gf_mul(a[1], 8'h02) ^ gf_mul(a[2], 8'h03) ^ a[3];
                    t[4 * c + 2] = a[0] ^ a[1] ^ gf_mul(a[2], 8'h02) ^ gf_mul(a[3], 8'h03);
                    t[4 * c + 3] = gf_mul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gf_mul(a[3], 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = t[k] ^ w[4 * r + k / 4][5'(31 - 8 * (k % 4)) -: 8];
        end
        for (int k = 0; k < 16; k++) res[7'(127 - 8 * k) -: 8] = s[k];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_block(input logic [127:0] pt, input logic [127:0] key,
                                output int acc_cyc, output bit to);
        bus.in_data  = pt;
        bus.in_key   = key;
        bus.in_valid = 1'b1;
        to = 1'b0;
        for (int n = 0; bus.in_ready !== 1'b1; n++) begin
            if (n > 50) begin
                to = 1'b1;
                break;
            end
            tick();
        end
        tick();
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int vcyc, output bit to);
        to = 1'b0;
        for (int n = 0; bus.out_valid !== 1'b1; n++) begin
            if (n > 50) begin
                to = 1'b1;
                break;
            end
            tick();
        end
        vcyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1, vc;
        bit to;
        bus.out_ready = 1'b1;
        accept_block(C1_PT, C1_KEY, acc0, to);
        checks++; if (to) begin failures++; $display("FAIL c1_accept got=timeout exp=accept"); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL c1_busy got=%b exp=1", bus.busy); end
        wait_valid(vc, to);
        checks++; if (to || vc - acc0 != 10) begin failures++; $display("FAIL c1_latency got=%0d exp=10 to=%b", vc - acc0, to); end
        checks++; if (bus.out_data !== C1_CT) begin failures++; $display("FAIL c1_data got=%h exp=%h", bus.out_data, C1_CT); end
        bus.in_data  = B_PT;
        bus.in_key   = B_KEY;
        bus.in_valid = 1'b1;
        tick();
        accept_block(B_PT, B_KEY, acc1, to);
        checks++; if (to || acc1 - acc0 != 12) begin failures++; $display("FAIL b2b_spacing got=%0d exp=12 to=%b", acc1 - acc0, to); end
        wait_valid(vc, to);
        checks++; if (to || vc - acc1 != 10) begin failures++; $display("FAIL b_latency got=%0d exp=10 to=%b", vc - acc1, to); end
        checks++; if (bus.out_data !== B_CT) begin failures++; $display("FAIL b_data got=%h exp=%h", bus.out_data, B_CT); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b_out_valid_drop got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        int acc, vc;
        bit to;
        bus.out_ready = 1'b0;
        accept_block('0, '0, acc, to);
        wait_valid(vc, to);
        checks++; if (to || bus.out_data !== Z_CT) begin failures++; $display("FAIL bp_data got=%h exp=%h to=%b", bus.out_data, Z_CT, to); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== Z_CT || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b r=%b d=%h exp v=1 r=0 d=%h", i, bus.out_valid, bus.in_ready, bus.out_data, Z_CT);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got r=%b v=%b b=%b exp r=1 v=0 b=0", bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_ignored_input();
        int acc;
        bit to;
        bus.out_ready = 1'b1;
        accept_block(C1_PT, C1_KEY, acc, to);
        for (int n = 0; n < 40 && bus.out_valid !== 1'b1; n++) begin
            bus.in_valid = n[0] ? 1'b0 : 1'b1;
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ign_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== C1_CT) begin failures++; $display("FAIL ign_data got=%h exp=%h", bus.out_data, C1_CT); end
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL ign_single got busy=%b rdy=%b exp busy=0 rdy=1", bus.busy, bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        int acc, vc;
        bit to;
        bus.out_ready = 1'b1;
        accept_block(C1_PT, C1_KEY, acc, to);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 128'h0) begin
            failures++;
            $display("FAIL rstmid_state got r=%b v=%b b=%b d=%h exp r=1 v=0 b=0 d=0", bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
        accept_block(C1_PT, C1_KEY, acc, to);
        wait_valid(vc, to);
        checks++; if (to || vc - acc != 10) begin failures++; $display("FAIL rstmid_latency got=%0d exp=10 to=%b", vc - acc, to); end
        checks++; if (bus.out_data !== C1_CT) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", bus.out_data, C1_CT); end
        tick();
    endtask

    task automatic test_random();
        logic [127:0] pt, key, exp;
        int acc, vc, hold;
        bit to;
        for (int b = 0; b < 6; b++) begin
            pt   = {$urandom, $urandom, $urandom, $urandom};
            key  = {$urandom, $urandom, $urandom, $urandom};
            exp  = aes_ref(pt, key);
            bus.out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            accept_block(pt, key, acc, to);
            wait_valid(vc, to);
            checks++; if (to || vc - acc != 10) begin failures++; $display("FAIL rand_latency blk=%0d got=%0d exp=10", b, vc - acc); end
            checks++; if (bus.out_data !== exp) begin failures++; $display("FAIL rand_data blk=%0d got=%h exp=%h", b, bus.out_data, exp); end
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
                failures++;
                $display("FAIL rand_hold blk=%0d got v=%b d=%h exp v=1 d=%h", b, bus.out_valid, bus.out_data, exp);
            end
            bus.out_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_blk_cnt();
        logic [127:0] pt, key, exp;
        int acc, vc;
        bit to;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            exp = aes_ref(pt, key);
            accept_block(pt, key, acc, to);
            wait_valid(vc, to);
            checks++; if (to || bus.out_data !== exp) begin failures++; $display("FAIL cnt_data blk=%0d got=%h exp=%h", b, bus.out_data, exp); end
            tick();
`ifdef AES128_ITER_BLKCNT_EN
            checks++;
            if (bus.blk_cnt !== TB_CNT_W'(b + 1)) begin
                failures++;
                $display("FAIL blk_cnt blk=%0d got=%0d exp=%0d", b, bus.blk_cnt, TB_CNT_W'(b + 1));
            end
`endif
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_ignored_input();
        test_reset_mid();
        test_random();
        test_blk_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
